// File: rtl/scan_mux.sv
// scan_mux: N-channel, W-bit selector with a registered output, manual select and dwell-based auto scan.
// Optional channel mask: define MUX_CH_MASK_EN to add the ch_mask input and skip masked channels.
module scan_mux #(
   parameter int N_CH  = 8,
   parameter int W     = 1,
   parameter int DWELL = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH*W-1:0] in_bus,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic              cont,
   input  logic              start,
   input  logic              stop,
`ifdef MUX_CH_MASK_EN
   input  logic [N_CH-1:0]   ch_mask,
`endif
   output logic [W-1:0]      out,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   output logic              busy,
   output logic              scan_done
);

   localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t          state, state_nx;
   logic [DW_W-1:0] dwell, dwell_nx;
   logic            cont_q, cont_nx;
   logic [W-1:0]    out_nx;
   logic [SEL_W-1:0] ch_nx;
   logic            valid_nx, done_nx;

   logic [N_CH-1:0] en;
`ifdef MUX_CH_MASK_EN
   assign en = ch_mask;
`else
   assign en = '1;
`endif

   function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] bus, input logic [SEL_W-1:0] c);
      pick = '0;
      for (int i = 0; i < N_CH; i++)
         if (c == SEL_W'(i)) pick = bus[i*W +: W];
   endfunction

   // {found, index} of the lowest enabled channel strictly above 'after'; after = -1 gives the first one
   function automatic logic [SEL_W:0] find_en(input logic [N_CH-1:0] m, input int after);
      find_en = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (m[i] && i > after) find_en = {1'b1, SEL_W'(i)};
   endfunction

   logic [SEL_W:0]   first_f, next_f, beyond_ld;
   logic [SEL_W-1:0] ld_ch;
   logic             dwell_end, adv_ok, ld_last, man_ok;

   always_comb begin
      first_f   = find_en(en, -1);
      next_f    = find_en(en, int'(out_ch));
      dwell_end = (dwell == DWELL_LAST);
      adv_ok    = next_f[SEL_W] | (cont_q & first_f[SEL_W]);
      if (state == IDLE || !next_f[SEL_W]) ld_ch = first_f[SEL_W-1:0];
      else                                 ld_ch = next_f[SEL_W-1:0];
      beyond_ld = find_en(en, int'(ld_ch));
      ld_last   = ~beyond_ld[SEL_W];
      man_ok    = 1'b0;
      for (int i = 0; i < N_CH; i++)
         if (sel == SEL_W'(i)) man_ok = en[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (mode && start && !stop && first_f[SEL_W]) state_nx = SCAN;
         SCAN:    if (stop || (dwell_end && !adv_ok)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      out_nx   = out;
      ch_nx    = out_ch;
      dwell_nx = dwell;
      cont_nx  = cont_q;
      valid_nx = 1'b0;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (!mode) begin
               out_nx   = man_ok ? pick(in_bus, sel) : '0;
               ch_nx    = sel;
               valid_nx = 1'b1;
            end else if (state_nx == SCAN) begin
               out_nx   = pick(in_bus, ld_ch);
               ch_nx    = ld_ch;
               dwell_nx = '0;
               cont_nx  = cont;
               valid_nx = (DWELL_LAST == '0);
               done_nx  = valid_nx && ld_last;
            end
         end
         SCAN: begin
            // leaving SCAN (stop or end of a one-shot pass) keeps out and out_ch as they were
            if (state_nx == SCAN) begin
               if (dwell_end) begin
                  out_nx   = pick(in_bus, ld_ch);
                  ch_nx    = ld_ch;
                  dwell_nx = '0;
                  valid_nx = (DWELL_LAST == '0);
                  done_nx  = valid_nx && ld_last;
               end else begin
                  out_nx   = pick(in_bus, out_ch);
                  dwell_nx = dwell + DW_W'(1);
                  valid_nx = (dwell_nx == DWELL_LAST);
                  done_nx  = valid_nx && !next_f[SEL_W];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         scan_done <= 1'b0;
         dwell     <= '0;
         cont_q    <= 1'b0;
      end else begin
         out       <= out_nx;
         out_ch    <= ch_nx;
         out_valid <= valid_nx;
         scan_done <= done_nx;
         dwell     <= dwell_nx;
         cont_q    <= cont_nx;
      end
   end

   assign busy = (state == SCAN);

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: manual-select table, directed scan sequences and random traffic for scan_mux.
// Scan behaviour is predicted from elapsed cycles since start (channel = t/DWELL, strobe on the last dwell cycle).
`timescale 1ns/1ps
module tb_scan_mux;
   localparam int N_CH     = 8;
   localparam int W        = 1;
   localparam int DWELL    = 4;
   localparam int SEL_W    = $clog2(N_CH);
   localparam int EW       = W + SEL_W + 3;
   localparam int PASS_CYC = N_CH * DWELL;

   // clock / reset and stimulus signals
   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic [N_CH*W-1:0] in_bus = '0;
   logic              mode  = 1'b0;
   logic [SEL_W-1:0]  sel   = '0;
   logic              cont  = 1'b0;
   logic              start = 1'b0;
   logic              stop  = 1'b0;
`ifdef MUX_CH_MASK_EN
   logic [N_CH-1:0]   ch_mask = '1;
`endif
   logic [W-1:0]      out;
   logic [SEL_W-1:0]  out_ch;
   logic              out_valid, busy, scan_done;

   scan_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
      .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode), .sel(sel),
      .cont(cont), .start(start), .stop(stop),
`ifdef MUX_CH_MASK_EN
      .ch_mask(ch_mask),
`endif
      .out(out), .out_ch(out_ch), .out_valid(out_valid), .busy(busy), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
      $fatal(1, "watchdog expired");
   end

   // scoreboard
   int             n_checks = 0;
   int             n_fail   = 0;
   logic [EW-1:0]  exp_q[$];
   string          phase    = "init";
   bit             model_on = 1'b1;

   // reference model state
   bit               m_scan, m_cont, m_valid, m_done;
   int               m_t;
   logic [W-1:0]     m_out;
   logic [SEL_W-1:0] m_ch;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   function automatic logic [W-1:0] chan(input logic [N_CH*W-1:0] bus, input int c);
      logic [W-1:0] r;
      r = '0;
      if (c < N_CH) r = bus[c*W +: W];
      return r;
   endfunction

   task automatic model_reset();
      m_scan = 0; m_cont = 0; m_valid = 0; m_done = 0; m_t = 0;
      m_out = '0; m_ch = '0;
   endtask

   task automatic model_scan_outputs();
      m_ch    = SEL_W'((m_t / DWELL) % N_CH);
      m_out   = chan(in_bus, int'(m_ch));
      m_valid = (m_t % DWELL) == DWELL - 1;
      m_done  = m_valid && (int'(m_ch) == N_CH - 1);
   endtask

   task automatic model_edge();
      if (!m_scan) begin
         m_done = 0;
         if (!mode) begin
            m_out = chan(in_bus, int'(sel)); m_ch = sel; m_valid = 1;
         end else if (start && !stop) begin
            m_scan = 1; m_t = 0; m_cont = cont;
            model_scan_outputs();
         end else begin
            m_valid = 0;
         end
      end else if (stop || (!m_cont && m_t + 1 >= PASS_CYC)) begin
         m_scan = 0; m_valid = 0; m_done = 0;
      end else begin
         m_t++;
         model_scan_outputs();
      end
      exp_q.push_back({m_out, m_ch, m_valid, m_scan, m_done});
   endtask

   // driver: advance one clock, update the model with the inputs seen at the edge, compare
   task automatic step();
      logic [EW-1:0] e;
      @(posedge clk);
      #1;
      if (!rst_n) model_reset();
      else if (model_on) model_edge();
      if (model_on && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({phase, "_cycle"}, {out, out_ch, out_valid, busy, scan_done}, e);
      end
   endtask

   typedef struct {
      logic [N_CH*W-1:0] bus;
      logic [SEL_W-1:0]  s;
      logic [W-1:0]      eo;
   } vec_t;
   vec_t vt[6];

   initial begin
      int nv, done_at, fall_at, last_v, d1, d2, extra;
      logic [W-1:0] seq_exp[N_CH];
      logic [N_CH*W-1:0] cb;
      logic [W-1:0] held;

      vt[0] = '{8'b00010100, 3'd2, 1'b1};
      vt[1] = '{8'b00010100, 3'd3, 1'b0};
      vt[2] = '{8'b00010100, 3'd4, 1'b1};
      vt[3] = '{8'b00010100, 3'd0, 1'b0};
      vt[4] = '{8'b11101011, 3'd4, 1'b0};
      vt[5] = '{8'b11101011, 3'd7, 1'b1};
      seq_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      // reset state
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check("reset_out", out, 0);
      check("reset_out_ch", out_ch, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_scan_done", scan_done, 0);
      step();
      @(negedge clk) rst_n = 1'b1;

      // manual select table
      phase = "manual";
      mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_bus = vt[i].bus;
         sel    = vt[i].s;
         step();
         check("manual_out", out, vt[i].eo);
         check("manual_out_ch", out_ch, vt[i].s);
         check("manual_valid", out_valid, 1);
      end

      // simultaneous start and stop in IDLE
      phase = "startstop";
      mode = 1'b1; start = 1'b1; stop = 1'b1;
      step();
      check("startstop_busy", busy, 0);
      start = 1'b0; stop = 1'b0;
      step();
      check("startstop_busy_after", busy, 0);

      // one-shot scan, with a stray start mid-scan
      phase = "oneshot";
      in_bus = 8'b10010111; cont = 1'b0; start = 1'b1;
      step();
      start = 1'b0; cont = 1'b1;
      check("oneshot_busy0", busy, 1);
      check("oneshot_ch0", out_ch, 0);
      nv = 0; done_at = -1; fall_at = -1; last_v = -1;
      for (int j = 1; j <= PASS_CYC + 4; j++) begin
         start = (j == 10);
         step();
         if (out_valid) begin
            if (nv < N_CH) check("oneshot_strobe_out", out, seq_exp[nv]);
            if (nv == 0) check("oneshot_first_strobe", j, DWELL - 1);
            else         check("oneshot_strobe_spacing", j - last_v, DWELL);
            nv++;
            last_v = j;
         end
         if (scan_done) done_at = j;
         if (!busy && fall_at < 0) fall_at = j;
      end
      start = 1'b0;
      check("oneshot_strobe_count", nv, N_CH);
      check("oneshot_done_with_ch7", done_at, PASS_CYC - 1);
      check("oneshot_busy_fall", fall_at, PASS_CYC);

      // continuous scan, then abort at channel 5 of the third pass
      phase = "cont";
      cb = 8'b00101110; in_bus = cb; cont = 1'b1; start = 1'b1;
      step();
      start = 1'b0; cont = 1'b0;
      d1 = -1; d2 = -1;
      for (int j = 1; j <= 2 * PASS_CYC + 21; j++) begin
         step();
         if (out_valid) check("cont_strobe_out", out, cb[out_ch]);
         if (scan_done) begin
            if (d1 < 0) d1 = j;
            else if (d2 < 0) d2 = j;
         end
         if (j == PASS_CYC) begin
            check("cont_wrap_ch0", out_ch, 0);
            check("cont_wrap_busy", busy, 1);
         end
      end
      check("cont_first_done", d1, PASS_CYC - 1);
      check("cont_done_period", d2 - d1, PASS_CYC);
      check("cont_at_ch5", out_ch, 5);
      held = out;
      stop = 1'b1;
      step();
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_no_valid", out_valid, 0);
      check("stop_no_done", scan_done, 0);
      check("stop_out_hold", out, held);
      extra = 0;
      for (int j = 0; j < 40; j++) begin
         step();
         if (out_valid || scan_done) extra++;
      end
      check("stop_quiet", extra, 0);

      // asynchronous reset mid-scan at channel 3, then restart from channel 0
      phase = "midreset";
      in_bus = 8'hff; cont = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      for (int j = 1; j <= 13; j++) step();
      check("midreset_at_ch3", out_ch, 3);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_out", out, 0);
      check("midreset_out_ch", out_ch, 0);
      check("midreset_valid", out_valid, 0);
      check("midreset_busy", busy, 0);
      check("midreset_done", scan_done, 0);
      model_reset();
      exp_q.delete();
      step();
      step();
      @(negedge clk) rst_n = 1'b1;
      start = 1'b1; cont = 1'b0;
      step();
      start = 1'b0;
      check("restart_ch0", out_ch, 0);
      check("restart_busy", busy, 1);
      for (int j = 1; j <= PASS_CYC + 2; j++) step();

      // random traffic against the model
      phase = "random";
      for (int j = 0; j < 1500; j++) begin
         in_bus = (N_CH*W)'($urandom);
         mode   = ($urandom_range(0, 3) != 0);
         sel    = SEL_W'($urandom_range(0, N_CH - 1));
         cont   = 1'($urandom_range(0, 1));
         start  = ($urandom_range(0, 7) == 0);
         stop   = ($urandom_range(0, 39) == 0);
         step();
      end
      start = 1'b0; stop = 1'b0;

`ifdef MUX_CH_MASK_EN
      // masked scan: only ch1 and ch3 strobe
      phase = "mask";
      model_on = 1'b0;
      mode = 1'b1; stop = 1'b1;
      step();
      stop = 1'b0;
      ch_mask = 8'b00001010; in_bus = 8'b10010111; cont = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      nv = 0; done_at = -1;
      for (int j = 0; j < 3 * DWELL; j++) begin
         step();
         if (out_valid) begin
            check("mask_strobe_ch", out_ch, (nv == 0) ? 1 : 3);
            check("mask_strobe_out", out, (nv == 0) ? 1 : 0);
            if (scan_done) done_at = int'(out_ch);
            nv++;
         end
      end
      check("mask_strobe_count", nv, 2);
      check("mask_done_ch3", done_at, 3);
      check("mask_busy_end", busy, 0);
      ch_mask = '0; start = 1'b1;
      step();
      start = 1'b0;
      check("mask_zero_busy", busy, 0);
      ch_mask = '1;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scan_mux.md
# scan_mux

Parametrised N-channel, W-bit selector with a registered output and two modes: manual select, and an automatic channel scan that dwells a fixed number of cycles per channel. It is the clocked successor to the team's combinational 8:1 mux. It sits between a bank of input channels and a single downstream sampler, and provides a per-channel sample strobe and end-of-scan indication.

## Interface
- N_CH, 8, number of input channels (≥2)
- W, 1, bits per channel
- DWELL, 4, cycles spent on each channel in scan mode (≥1)
- SEL_W, $clog2(N_CH), derived channel-index width (local)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_bus  input  N_CH*W  channel c occupies bits [c*W +: W]
- mode  input  1  0 = manual, 1 = scan; sampled only in IDLE
- sel  input  SEL_W  manual channel index
- cont  input  1  1 = continuous scan, 0 = one-shot; sampled at start
- start  input  1  single-cycle scan request
- stop  input  1  abort scan
- out  output  W  registered selected channel data
- out_ch  output  SEL_W  index of the channel currently driving out
- out_valid  output  1  sample strobe
- busy  output  1  high while in SCAN
- scan_done  output  1  one-cycle pulse at the end of each full pass

## Operation
- Reset values: out=0, out_ch=0, out_valid=0, busy=0, scan_done=0; state IDLE; dwell counter 0.
- States: IDLE, SCAN.
- IDLE with mode=0: out<=in_bus[sel], out_ch<=sel, out_valid<=1 every cycle.
- IDLE with mode=1: out_valid<=0 and out holds, unless start is sampled.
- Start: start=1 in IDLE with mode=1 and stop=0 moves to SCAN. out<=in_bus[0], out_ch<=0, dwell<=0, cont is latched.
- SCAN, every cycle: out<=in_bus[out_ch], so live input changes propagate with 1-cycle latency.
- SCAN dwell: dwell counts 0..DWELL-1. out_valid=1 only during the final dwell cycle of each channel.
- Channel advance: at the end of a dwell, out_ch advances, out loads the next channel, and dwell<=0.
- Last channel (N_CH-1): scan_done pulses together with its out_valid.
  - If cont=1: wrap to channel 0.
  - If cont=0: return to IDLE.
- stop=1 in SCAN: return to IDLE at the next edge. No out_valid or scan_done is issued that cycle; out holds its last value.
- start and stop asserted together: stop wins.
- start while in SCAN: ignored.
- mode and sel changes in SCAN: ignored.
- sel ≥ N_CH (N_CH not a power of two): out<=0, out_valid still 1.
- Asynchronous reset mid-scan: all outputs clear immediately; the next scan restarts from channel 0.

## Timing
- Manual latency: 1 cycle from sel/in_bus change to out.
- Start sampled at edge k: busy=1 and out_ch=0 from k+1.
- First out_valid is in cycle k+DWELL.
- One-shot scan: N_CH*DWELL cycles; busy falls at edge k+N_CH*DWELL.
- Continuous scan: scan_done period is N_CH*DWELL cycles.
- DWELL=1: out_valid is high every SCAN cycle.
- No combinational path from any input to any output.

## Configuration
- MUX_CH_MASK_EN defined:
  - Adds input ch_mask [N_CH-1:0].
  - Scan visits only channels whose mask bit is 1. The next enabled channel is found in one cycle, with no extra dwell.
  - scan_done pulses after the highest enabled channel.
  - start with ch_mask=0 is ignored (busy stays 0).
  - Manual select of a masked channel gives out=0.
  - ch_mask is sampled at each channel advance.
- MUX_CH_MASK_EN not defined: no ch_mask port; all N_CH channels are scanned.

## Test plan
- Reset: assert rst_n=0 mid-scan at channel 3 -> out, out_ch, out_valid, busy, scan_done all 0 before the next clock edge; the following start scans from channel 0.
- Manual: N_CH=8, W=1, in_bus=8'b00010100, mode=0, sel=2 -> out=1 one cycle later; sel=3 -> out=0; sel=4 -> out=1; out_valid constantly 1.
- One-shot scan: DWELL=4, in_bus=8'b10010111, cont=0, start pulse -> 8 out_valid pulses spaced 4 cycles apart, with out=1,1,1,0,1,0,0,1 for ch0..7; scan_done coincides with the ch7 strobe; busy low 32 cycles after start.
- Continuous scan with abort: in_bus=8'b00101110, cont=1 -> after ch7 out_ch wraps to 0 and scan_done repeats every 32 cycles; stop at ch5 -> busy=0 next cycle, no further out_valid or scan_done.
- Simultaneous start/stop in IDLE -> remains IDLE, busy=0; a second start while busy -> no restart, out_ch sequence undisturbed.
- MUX_CH_MASK_EN: ch_mask=8'b00001010, in_bus=8'b10010111 -> strobes only for ch1 (out=1) and ch3 (out=0), scan_done with ch3; ch_mask=0 with start -> busy stays 0.
